score_display_scheduler: RTL

Sequencer for the 8-digit seven-segment score display. It accepts a binary score over a valid/ready handshake and converts it to BCD with a serial double-dabble engine. It holds the committed digits and time-multiplexes the display by stepping `refreshcounter`, driving active-low anodes and presenting one glyph code per slot to the segment decoder. It sits between the game-logic score counter and the segment decoder / anode pins.

---
 rtl/score_display_pkg.sv | 60 ++++++
 rtl/score_display_scheduler_bin2bcd_dd.sv | 51 +++++
 rtl/score_display_scheduler.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/score_display_pkg.sv
// ---------------------------------------------------------------------------
// score_display_pkg
// Shared types and constants for the 8-digit score display scheduler.
//   state_t       : sequencer FSM states (IDLE, CONVERT, COMMIT)
//   GLYPH_*       : glyph codes understood by the downstream segment decoder
//   SLOT_*        : digit slot indices, 0 = rightmost
//   dd_step()     : one double-dabble iteration on the 20-bit working register
// ---------------------------------------------------------------------------
package score_display_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    localparam logic [7:0] GLYPH_S     = 8'h05;
    localparam logic [7:0] GLYPH_C     = 8'h0C;
    localparam logic [7:0] GLYPH_O     = 8'h00;
    localparam logic [7:0] GLYPH_R     = 8'h0D;
    localparam logic [7:0] GLYPH_E     = 8'h0E;
    localparam logic [7:0] GLYPH_BLANK = 8'hFF;
    localparam logic [7:0] GLYPH_DASH  = 8'hFE;

    localparam logic [2:0] SLOT_ONES     = 3'd0;
    localparam logic [2:0] SLOT_TENS     = 3'd1;
    localparam logic [2:0] SLOT_HUNDREDS = 3'd2;
    localparam logic [2:0] SLOT_E        = 3'd3;
    localparam logic [2:0] SLOT_R        = 3'd4;
    localparam logic [2:0] SLOT_O        = 3'd5;
    localparam logic [2:0] SLOT_C        = 3'd6;
    localparam logic [2:0] SLOT_S        = 3'd7;

    // Number of shift steps needed to convert an 8-bit binary value.
    localparam int BIN_W = 8;

    // One double-dabble step: every BCD nibble that is 5 or more gets 3 added
    // so that the following left shift carries correctly into the next decade.
    // Layout is {hundreds, tens, ones, bin}.
    function automatic logic [19:0] dd_step(input logic [19:0] r);
        logic [19:0] a;
        a = r;
        if (a[11:8] >= 4'd5) begin
            a[11:8] = a[11:8] + 4'd3;
        end
        if (a[15:12] >= 4'd5) begin
            a[15:12] = a[15:12] + 4'd3;
        end
        if (a[19:16] >= 4'd5) begin
            a[19:16] = a[19:16] + 4'd3;
        end
        return {a[18:0], 1'b0};
    endfunction

    // Numeric digit to glyph code; digits map straight onto the low nibble.
    function automatic logic [7:0] digit_glyph(input logic [3:0] d);
        return {4'h0, d};
    endfunction

endpackage

// File: rtl/score_display_scheduler_bin2bcd_dd.sv
// ---------------------------------------------------------------------------
// bin2bcd_dd
// Serial double-dabble binary-to-BCD converter, one shift per clock.
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   start in   load 'bin' into the working register (ignored while active)
//   bin   in   8-bit unsigned value
//   done  out  high during the cycle whose rising edge performs the 8th shift
//   bcd   out  {hundreds, tens, ones}; final once the 8th shift has happened
// ---------------------------------------------------------------------------
module bin2bcd_dd
    import score_display_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        done,
    output logic [11:0] bcd
);

    logic [19:0] shift_reg;
    logic [2:0]  shift_cnt;
    logic        active;

    // Load on start, then apply one add-3/shift step per cycle. The counter
    // wraps back to 0 on the last step, so it is ready for the next load.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            shift_cnt <= '0;
            active    <= 1'b0;
        end else if (start && !active) begin
            shift_reg <= {12'd0, bin};
            shift_cnt <= '0;
            active    <= 1'b1;
        end else if (active) begin
            shift_reg <= dd_step(shift_reg);
            shift_cnt <= shift_cnt + 3'd1;
            if (shift_cnt == 3'(BIN_W - 1)) begin
                active <= 1'b0;
            end
        end
    end

    // 'done' marks the cycle ending in the last shift so the sequencer can
    // move to COMMIT on that same edge and pick up the result a cycle later.
    assign done = active && (shift_cnt == 3'(BIN_W - 1));
    assign bcd  = shift_reg[19:8];

endmodule

// File: rtl/score_display_scheduler.sv
// ---------------------------------------------------------------------------
// score_display_scheduler
// Accepts a binary score over valid/ready, converts it to BCD and scans it,
// prefixed by "SCORE", across an 8-digit multiplexed seven-segment display.
//   REFRESH_DIV     clock cycles per digit slot (>= 2)
//   clk             system clock, rising edge
//   rst             synchronous active-high reset
//   score           unsigned binary score, 0..255
//   score_valid     score is valid this cycle
//   score_ready     a score can be accepted this cycle
//   refreshcounter  active digit slot, 0 = rightmost
//   an              active-low anode enables, registered
//   digit_code      glyph code for the active slot
//   busy            conversion in progress
// ---------------------------------------------------------------------------
module score_display_scheduler
    import score_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] score,
    input  logic       score_valid,
    output logic       score_ready,
    output logic [2:0] refreshcounter,
    output logic [7:0] an,
    output logic [7:0] digit_code,
    output logic       busy
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

    state_t      state;
    state_t      state_next;
    logic        conv_start;
    logic        conv_done;
    logic [11:0] conv_bcd;
    logic [3:0]  disp_hundreds;
    logic [3:0]  disp_tens;
    logic [3:0]  disp_ones;
    logic [PW-1:0] presc;
    logic [2:0]  next_slot;

    // Ready is masked by reset so nothing is accepted on a reset edge.
    assign score_ready = (state == IDLE) && !rst;
    assign conv_start  = score_valid && score_ready;
    assign busy        = (state != IDLE);

    bin2bcd_dd u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (score),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sequencer: the converter runs while in CONVERT; COMMIT is the single
    // cycle in which its settled result is copied to the display digits.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (conv_start) begin
                    state_next = CONVERT;
                end
            end
            CONVERT: begin
                if (conv_done) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // All three digits load together so the scan never shows a mix of old
    // and new values, even when the commit lands on a slot change.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_hundreds <= '0;
            disp_tens     <= '0;
            disp_ones     <= '0;
        end else if (state == COMMIT) begin
            disp_hundreds <= conv_bcd[11:8];
            disp_tens     <= conv_bcd[7:4];
            disp_ones     <= conv_bcd[3:0];
        end
    end

    assign next_slot = refreshcounter + 3'd1;

    // Free-running prescaler and scan counter, independent of the FSM.
    // The anode pattern is registered alongside the slot so both change on
    // the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc          <= '0;
            refreshcounter <= SLOT_ONES;
            an             <= 8'hFE;
        end else if (presc == PRESC_LAST) begin
            presc          <= '0;
            refreshcounter <= next_slot;
            an             <= ~(8'h01 << next_slot);
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Glyph mux with leading-zero blanking of hundreds and tens; an inner
    // zero (e.g. 100) stays visible because tens only blanks when hundreds
    // is also zero.
    always_comb begin
        digit_code = GLYPH_DASH;
        case (refreshcounter)
            SLOT_S: digit_code = GLYPH_S;
            SLOT_C: digit_code = GLYPH_C;
            SLOT_O: digit_code = GLYPH_O;
            SLOT_R: digit_code = GLYPH_R;
            SLOT_E: digit_code = GLYPH_E;
            SLOT_HUNDREDS: begin
                if (disp_hundreds == 4'd0) begin
                    digit_code = GLYPH_BLANK;
                end else begin
                    digit_code = digit_glyph(disp_hundreds);
                end
            end
            SLOT_TENS: begin
                if ((disp_hundreds == 4'd0) && (disp_tens == 4'd0)) begin
                    digit_code = GLYPH_BLANK;
                end else begin
                    digit_code = digit_glyph(disp_tens);
                end
            end
            SLOT_ONES: begin
                digit_code = digit_glyph(disp_ones);
            end
            default: begin
                digit_code = GLYPH_DASH;
            end
        endcase
    end

endmodule
